// File: rtl/ldpc_encode.sv
// ldpc_encode: systematic quasi-cyclic LDPC encoder, 1024 info bytes in, 128 parity bytes out.
// One info byte is folded into the 1024-bit parity accumulator per cycle; parity streams out on request.

module ldpc_encode_rom (
    input  logic [4:0]   addr,
    output logic [255:0] data
);
    // First rows of one circulant column; contents are loaded from outside the design.
    logic [255:0] ROM [0:31];

    assign data = ROM[addr];
endmodule

module ldpc_encode_g2 (
    input  logic [4:0]    addr,
    output logic [1023:0] rows
);
    ldpc_encode_rom k0 (.addr(addr), .data(rows[1023:768]));
    ldpc_encode_rom k1 (.addr(addr), .data(rows[767:512]));
    ldpc_encode_rom k2 (.addr(addr), .data(rows[511:256]));
    ldpc_encode_rom k3 (.addr(addr), .data(rows[255:0]));
endmodule

module ldpc_encode (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] d_in,
    input  logic       en_start,
    input  logic       en_din,
    input  logic       read_parity,
    output logic       done_encode,
    output logic       en_out,
    output logic [7:0] d_out
);
    localparam int N_IN_BYTES  = 1024;
    localparam int N_PAR_BYTES = 128;

    logic             en_start_q;
    logic             en_d;
    logic             active;
    logic [10:0]      byte_cnt;
    logic [255:0]     acc [4];
    logic [6:0]       out_cnt;

    logic             start_edge;
    logic             take;
    logic             rd_go;
    logic [9:0]       byte_idx;
    logic [1023:0]    g2_rows;
    logic [255:0]     base;
    logic [255:0]     contrib [4];
    logic [1023:0]    par_flat;
    logic [6:0]       rd_idx;
    logic [7:0]       rd_byte;

    // Rotating the vector right moves column c to column c+1 (column 0 sits at bit 255).
    function automatic logic [255:0] rotr(input logic [255:0] x, input logic [7:0] s);
        logic [511:0] d;
        d = {x, x} >> s;
        return d[255:0];
    endfunction

    assign start_edge = en_start & ~en_start_q;
    // byte_cnt[10] marks a full codeword; further captures are dropped until the next start.
    assign take       = en_d & (start_edge | (active & ~byte_cnt[10]));
    assign byte_idx   = start_edge ? 10'd0 : byte_cnt[9:0];

    ldpc_encode_g2 e2 (.addr(byte_idx[9:5]), .rows(g2_rows));

    // All 8 bits of a byte share one block row; byte offset in the block gives the base rotation.
    always_comb begin
        base    = '0;
        contrib = '{default: '0};
        for (int j = 0; j < 4; j++) begin
            base = rotr(g2_rows[1023 - 256*j -: 256], {byte_idx[4:0], 3'b000});
            for (int b = 0; b < 8; b++) begin
                if (d_in[7-b]) begin
                    contrib[j] = contrib[j] ^ rotr(base, 8'(b));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_start_q  <= 1'b0;
            en_d        <= 1'b0;
            active      <= 1'b0;
            byte_cnt    <= '0;
            done_encode <= 1'b0;
            for (int j = 0; j < 4; j++) acc[j] <= '0;
        end else begin
            en_start_q <= en_start;
            en_d       <= en_din;
            if (start_edge) begin
                active      <= 1'b1;
                done_encode <= 1'b0;
                byte_cnt    <= take ? 11'd1 : 11'd0;
                for (int j = 0; j < 4; j++) acc[j] <= contrib[j];
            end else if (take) begin
                byte_cnt <= byte_cnt + 11'd1;
                if (byte_cnt == 11'(N_IN_BYTES - 1)) done_encode <= 1'b1;
                for (int j = 0; j < 4; j++) acc[j] <= acc[j] ^ contrib[j];
            end
        end
    end

    assign par_flat = {acc[0], acc[1], acc[2], acc[3]};
    assign rd_go    = read_parity & done_encode & ~en_out & ~start_edge;
    assign rd_idx   = rd_go ? 7'd0 : out_cnt + 7'd1;
    assign rd_byte  = par_flat[10'd1023 - {rd_idx, 3'b000} -: 8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_out  <= 1'b0;
            d_out   <= '0;
            out_cnt <= '0;
        end else if (start_edge) begin
            en_out  <= 1'b0;
            d_out   <= '0;
            out_cnt <= '0;
        end else if (rd_go) begin
            en_out  <= 1'b1;
            d_out   <= rd_byte;
            out_cnt <= '0;
        end else if (en_out) begin
            if (out_cnt == 7'(N_PAR_BYTES - 1)) begin
                en_out <= 1'b0;
                d_out  <= '0;
            end else begin
                out_cnt <= rd_idx;
                d_out   <= rd_byte;
            end
        end
    end
endmodule

// File: tb/tb_ldpc_encode.sv
// tb_ldpc_encode: directed bench for ldpc_encode with a bit-level GF(2) m*G2 reference model.
// ROM contents are written into the DUT hierarchy; words 0 and 1 are fixed so results can be hand-derived.

module tb_ldpc_encode;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] d_in = 8'h00;
    logic       en_start = 1'b0;
    logic       en_din = 1'b0;
    logic       read_parity = 1'b0;
    logic       done_encode;
    logic       en_out;
    logic [7:0] d_out;

    int n_vec = 0;
    int n_err = 0;

    bit         rom_col [4][32][256];
    bit         par_m [1024];
    logic [7:0] msg [1024];
    logic [7:0] exp_par [128];
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    ldpc_encode dut (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .en_start(en_start), .en_din(en_din),
        .read_parity(read_parity), .done_encode(done_encode), .en_out(en_out), .d_out(d_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Column c of a first row lives at word bit [255-c].
    task automatic load_rom();
        logic [255:0] w;
        for (int j = 0; j < 4; j++) begin
            for (int r = 0; r < 32; r++) begin
                for (int c = 0; c < 256; c++) w[255-c] = rom_col[j][r][c];
                case (j)
                    0: dut.e2.k0.ROM[r] = w;
                    1: dut.e2.k1.ROM[r] = w;
                    2: dut.e2.k2.ROM[r] = w;
                    default: dut.e2.k3.ROM[r] = w;
                endcase
            end
        end
    endtask

    task automatic set_rom_contents();
        logic [7:0] first_byte;
        for (int j = 0; j < 4; j++) begin
            first_byte = 8'hA0 + 8'(j);
            for (int c = 0; c < 256; c++) begin
                rom_col[j][0][c] = (c < 8) ? first_byte[7-c] : (c == 255);
                rom_col[j][1][c] = (c >= 2 && c <= 5);
                for (int r = 2; r < 32; r++) rom_col[j][r][c] = 1'($urandom_range(0, 1));
            end
        end
    endtask

    // Straight from the definition: every set message bit i XORs row (i mod 256) of block row i/256.
    task automatic compute_model();
        int r, t;
        foreach (par_m[p]) par_m[p] = 1'b0;
        for (int i = 0; i < 8192; i++) begin
            if (msg[i/8][7 - (i % 8)]) begin
                r = i / 256;
                t = i % 256;
                for (int j = 0; j < 4; j++)
                    for (int c = 0; c < 256; c++)
                        par_m[j*256 + c] ^= rom_col[j][r][(c - t + 256) % 256];
            end
        end
        for (int k = 0; k < 128; k++)
            for (int b = 0; b < 8; b++) exp_par[k][7-b] = par_m[8*k + b];
    endtask

    task automatic clear_msg();
        foreach (msg[n]) msg[n] = 8'h00;
    endtask

    task automatic random_msg();
        foreach (msg[n]) msg[n] = 8'($urandom_range(0, 255));
    endtask

    // Start edge with the first request; byte for request k is presented one cycle after it.
    task automatic run_message();
        for (int k = 0; k <= 1025; k++) begin
            @(posedge clk); #1;
            en_start = (k == 0);
            en_din   = (k < 1024);
            d_in     = (k >= 1 && k <= 1024) ? msg[k-1] : 8'h00;
            if (k == 1024) begin
                @(negedge clk);
                check("done_before_last_byte", done_encode, 1'b0);
            end
            if (k == 1025) begin
                @(negedge clk);
                check("done_after_last_byte", done_encode, 1'b1);
            end
        end
    endtask

    task automatic partial_feed(input int n);
        for (int k = 0; k <= n + 1; k++) begin
            @(posedge clk); #1;
            en_start = (k == 0);
            en_din   = (k < n);
            d_in     = (k >= 1 && k <= n) ? 8'($urandom_range(0, 255)) : 8'h00;
        end
    endtask

    task automatic start_read(input bit expect_out);
        @(posedge clk); #1;
        read_parity = 1'b1;
        if (expect_out) foreach (exp_par[k]) exp_q.push_back(exp_par[k]);
        @(posedge clk); #1;
        read_parity = 1'b0;
    endtask

    task automatic do_read(input bit expect_out);
        int hi, gap;
        hi  = 0;
        gap = 0;
        start_read(expect_out);
        for (int c = 0; c < 140; c++) begin
            @(negedge clk);
            if (en_out) hi++;
            else if (c < 128) gap++;
        end
        check("en_out_cycles", hi, expect_out ? 128 : 0);
        if (expect_out) check("en_out_contiguous_from_next_cycle", gap, 0);
        check("exp_q_drained", exp_q.size(), 0);
        check("d_out_idle_zero", d_out, 8'h00);
    endtask

    task automatic async_reset_check(input string tag);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check({tag, "_done_zero"}, done_encode, 1'b0);
        check({tag, "_en_out_zero"}, en_out, 1'b0);
        check({tag, "_d_out_zero"}, d_out, 8'h00);
        exp_q.delete();
        en_din = 1'b0;
        d_in   = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && en_out) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_en_out: d_out=%0h with no byte expected", d_out);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("d_out", d_out, e);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        set_rom_contents();
        load_rom();
        repeat (3) @(posedge clk);
        #1;
        check("reset_done", done_encode, 1'b0);
        check("reset_en_out", en_out, 1'b0);
        check("reset_d_out", d_out, 8'h00);
        rst_n = 1'b1;

        // readout requested before any codeword is complete
        do_read(1'b0);

        clear_msg();
        compute_model();
        check("model_zero_byte0", exp_par[0], 8'h00);
        run_message();
        do_read(1'b1);

        clear_msg();
        msg[0] = 8'h80;
        compute_model();
        check("model_bit0_byte0", exp_par[0], 8'hA0);
        check("model_bit0_byte31", exp_par[31], 8'h01);
        check("model_bit0_byte32", exp_par[32], 8'hA1);
        check("model_bit0_byte96", exp_par[96], 8'hA3);
        run_message();
        do_read(1'b1);

        clear_msg();
        msg[0] = 8'h40;
        compute_model();
        check("model_bit1_byte0", exp_par[0], 8'hD0);
        check("model_bit1_byte31", exp_par[31], 8'h00);
        check("model_bit1_byte32", exp_par[32], 8'hD0);
        check("model_bit1_byte33", exp_par[33], 8'h80);
        run_message();
        do_read(1'b1);

        clear_msg();
        msg[32] = 8'h80;
        compute_model();
        check("model_word1_byte0", exp_par[0], 8'h3C);
        check("model_word1_byte1", exp_par[1], 8'h00);
        check("model_word1_byte32", exp_par[32], 8'h3C);
        run_message();
        do_read(1'b1);
        // done stays high, so a second request repeats the same parity
        do_read(1'b1);

        // restart mid-stream: only the second message may count
        partial_feed(500);
        random_msg();
        compute_model();
        run_message();
        do_read(1'b1);

        partial_feed(300);
        async_reset_check("rst_mid_capture");
        random_msg();
        compute_model();
        run_message();
        do_read(1'b1);

        start_read(1'b1);
        repeat (50) @(negedge clk);
        async_reset_check("rst_mid_readout");
        do_read(1'b0);
        run_message();
        do_read(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ldpc_encode.md
Name: ldpc_encode

Overview:
- Systematic quasi-cyclic LDPC encoder: 8192 info bits (1024 bytes) -> 1024 parity bits (128 bytes).
- Computes parity p = m·G2 over GF(2). G2 is 32×4 circulants of 256×256, stored as first rows in four ROMs.
- Streams parity out bytewise on request.
- Sits between the byte-wide data source and the channel framer, which concatenates info and parity.

Parameters:
- N_IN_BYTES, 1024, info bytes per codeword
- N_PAR_BYTES, 128, parity bytes per codeword
- CIRC, 256, circulant size in bits
- N_BROW, 32, circulant block rows (8192/CIRC)
- N_BCOL, 4, circulant block columns (1024/CIRC)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- d_in  in  8  info byte; d_in[7] is the earlier message bit
- en_start  in  1  codeword start; rising edge only is significant
- en_din  in  1  input request; byte for request n is valid on d_in the cycle after en_din is sampled high
- read_parity  in  1  one-cycle parity readout request
- done_encode  out  1  all 1024 bytes accumulated; parity valid
- en_out  out  1  d_out valid qualifier
- d_out  out  8  parity byte; d_out[7] = lower parity index

Behaviour:
- Reset (async, rst_n=0):
  - done_encode=0, en_out=0, d_out=0.
  - Accumulators, byte counter, output counter and all delay flops cleared.
- Hierarchy:
  - Submodule instance e2 contains four ROM instances k0..k3.
  - Each ROM holds an array named ROM: 32 words × 256 bits, loaded externally with $readmemb.
  - Word r of ROM kj = first row of circulant (r,j); word bit [255-c] = column c.
  - ROM read is combinational.
- Circulant row t of (r,j) = first row cyclically shifted by t: column c = first-row column (c−t) mod 256.
- Message bit i = 8·n + b, where n = byte index and b=0 is d_in[7].
  - Block row r = i/256; row-in-circulant t = i%256.
  - If bit i = 1: parity[j·256+c] ^= row t of circulant (r,j), for all j.
- Start:
  - Rising edge of en_start (en_start=1, previous sample 0) clears accumulators, byte counter and done_encode, and aborts any readout.
  - A level held high has no further effect.
  - A capture in the same cycle as the start edge is processed after the clear.
- Capture:
  - Internal flop en_d = en_din delayed one cycle. Each cycle en_d=1, d_in is accumulated (all 8 bits, one cycle per byte).
  - Byte counter 0..1023 is incremented per capture.
  - Captures beyond 1024 before a new start are ignored.
- done_encode:
  - Goes 1 the cycle after the 1024th byte is accumulated.
  - Holds until the next start edge or reset.
- Readout:
  - read_parity sampled 1 while done_encode=1 and no readout active -> en_out=1 from the next cycle for exactly 128 consecutive cycles.
  - d_out = parity bytes 0..127 in order; byte k bit [7-b] = parity[8k+b].
  - read_parity while done_encode=0 or during a readout is ignored.
- After readout: en_out=0, d_out=0. done_encode stays 1, so a later read_parity repeats the readout.
- Reset mid-operation aborts everything; a new en_start edge is then required.

Test Plan:
- All-zero message (1024 × 0x00), then read_parity -> done_encode=1 after the 1024th capture; en_out high 128 cycles; every d_out = 0x00.
- Only byte 0 = 0x80 (bit 0), rest zero -> parity = concatenation of ROM k0..k3 word 0 (256 bits each), MSB-first.
- Only byte 0 = 0x40 (bit 1) -> parity = each word-0 row rotated by 1 column. Byte 32 = 0x80 -> word 1 rows unrotated.
- Random 1024-byte message -> 128 output bytes match a golden GF(2) m·G2 model. Timing: en_start edge, en_din held 1024 cycles, read_parity pulse after done; en_out asserted exactly 128 cycles starting the cycle after the read_parity sample.
- read_parity pulsed before done_encode -> no en_out. Second en_start edge mid-stream -> accumulators cleared, result reflects the new 1024 bytes only.
- Assert rst_n=0 mid-capture and mid-readout -> outputs 0 immediately (asynchronously). Re-run from start gives the correct parity.
